pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the `en`/`flush` pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC load enable. It also gates instruction- and data-memory requests, and holds responses that complete early while the other port is still busy, so no fetched word or load result is lost. It handles multi-cycle cache latency, load-use hazards and EX-stage branch/jump redirects, and keeps two performance counters.

## Interface
Parameters:
- `RESET_CNT`, default 0: reset value of both performance counters.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_resp`  in  1  I-cache response pulse.
- `imem_rdata`  in  32  I-cache read data, valid with `imem_resp`.
- `imem_read`  out  1  I-cache read request.
- `instr_out`  out  32  instruction word to the IF/ID `imem_rdata_in`.
- `ex_dmem_read`  in  1  MEM-stage instruction requests a load.
- `ex_dmem_write`  in  1  MEM-stage instruction requests a store.
- `dmem_resp`  in  1  D-cache response pulse.
- `dmem_rdata`  in  32  D-cache read data.
- `dmem_read`  out  1  D-cache read request.
- `dmem_write`  out  1  D-cache write request.
- `load_data_out`  out  32  load data to the MEM/WB register.
- `br_redirect`  in  1  EX resolved a taken branch or jump.
- `idex_mem_read`  in  1  instruction in EX is a load.
- `idex_rd`  in  5  EX destination register.
- `ifid_rs1`, `ifid_rs2`  in  5 each  ID source registers.
- `ifid_use_rs1`, `ifid_use_rs2`  in  1 each  ID actually reads rs1 / rs2.
- `pc_en`  out  1  PC load enable.
- `ifid_en`, `ifid_flush`  out  1 each  IF/ID control.
- `idex_en`, `idex_flush`  out  1 each  ID/EX control.
- `exmem_en`, `memwb_en`  out  1 each  EX/MEM and MEM/WB enables.
- `stall_cycles`  out  32  count of memory-stall cycles.
- `bubble_cycles`  out  32  count of load-use bubbles plus redirect flushes.

## Operation
- State:
  - `imem_done`, `dmem_done` (1 bit each).
  - `ibuf`, `dbuf` (32 bits each).
  - Both counters.
- Derived signals:
  - `dmem_need = ex_dmem_read | ex_dmem_write`.
  - `imem_ok = imem_resp | imem_done`.
  - `dmem_ok = ~dmem_need | dmem_resp | dmem_done`.
  - `mem_stall = ~(imem_ok & dmem_ok)`.
- Requests:
  - `imem_read = ~imem_done`.
  - `dmem_read = ex_dmem_read & ~dmem_done`.
  - `dmem_write = ex_dmem_write & ~dmem_done`.
- Data muxes:
  - `instr_out = imem_done ? ibuf : imem_rdata`.
  - `load_data_out = dmem_done ? dbuf : dmem_rdata`.
- Load-use hazard: `lu = idex_mem_read & idex_rd != 0 & ((ifid_use_rs1 & ifid_rs1 == idex_rd) | (ifid_use_rs2 & ifid_rs2 == idex_rd))`.
- Control outputs are combinational. Priority order, highest first:
  1. `rst`: all enables, flushes and requests are 0.
  2. `mem_stall`: all enables 0, both flushes 0.
  3. `br_redirect`: all enables 1, `ifid_flush=1`, `idex_flush=1`. The wrong-path instructions in IF/ID and ID/EX become NOPs; the PC loads the target.
  4. `lu`: `pc_en=0`, `ifid_en=0`, `idex_en=1`, `idex_flush=1`, `exmem_en=1`, `memwb_en=1`. One bubble is inserted and ID is held.
  5. Otherwise: all enables 1, flushes 0.
- Sequential updates:
  - Stall cycle with `imem_resp & ~imem_done`: `imem_done<=1`, `ibuf<=imem_rdata`. The same rule applies to `dmem_resp`, `dmem_done` and `dbuf`.
  - Any non-stall cycle: `imem_done<=0`, `dmem_done<=0`. Buffers are not cleared.
- Counters (32-bit, wrap modulo 2^32):
  - `stall_cycles` increments on every `mem_stall` cycle outside reset.
  - `bubble_cycles` increments on every non-stall cycle where `br_redirect | lu`.

## Timing
- Reset values: `imem_done=0`, `dmem_done=0`, `ibuf=0`, `dbuf=0`, both counters `RESET_CNT`.
- While `rst=1`, all control outputs are 0. In the first cycle after reset, `imem_read=1`.
- Zero-latency hit: `imem_resp` arrives in the same cycle as the request and `dmem_ok` holds. The pipeline advances that cycle and `instr_out = imem_rdata`.
- Early response:
  - `imem_resp` at cycle N while D is busy: `ibuf` is captured at the N edge and `imem_read` drops from N+1.
  - `dmem_resp` at M > N: the pipeline advances at M with `instr_out = ibuf`, and `imem_read` rises at M+1.
  - The mirror case (D-cache responds first) uses `dmem_done`/`dbuf` the same way.
- Simultaneous `imem_resp` and `dmem_resp`: the pipeline advances the same cycle and no done flag is set.
- `br_redirect` during a stall is not acted on until the stall clears. EX is frozen, so the signal is still present when the stall ends; no pending flag exists.
- `br_redirect` together with `lu`: redirect wins, and only the redirect is counted.
- Reset asserted mid-stall clears both done flags at that edge. Any in-flight response is then discarded.

## Test plan
- Reset: hold `rst` 2 cycles, then release, with `imem_resp` tied high. First non-reset cycle: all enables=1, `imem_read=1`, counters = 0.
- I-cache miss: `imem_resp` is low for 3 cycles, then pulses. Required: enables are 0 for 3 cycles and then 1, `stall_cycles=3`.
- Overlap:
  - Stimulus: load in MEM; `imem_resp` with `0x00A00093` at cycle 1; `dmem_resp` with `0xDEADBEEF` at cycle 4.
  - Required: `imem_read=0` in cycles 2–4; at cycle 4 `instr_out=0x00A00093`, `load_data_out=0xDEADBEEF`, enables=1.
- Load-use: `idex_mem_read=1`, `idex_rd=5`, `ifid_rs2=5`, `ifid_use_rs2=1`. Required: `pc_en=0`, `ifid_en=0`, `idex_flush=1`, `bubble_cycles` +1. Repeat with `idex_rd=0`: no bubble.
- Redirect plus load-use in the same cycle: `ifid_flush=1`, `idex_flush=1`, `pc_en=1`, `bubble_cycles` +1 only.
- Redirect during a D-miss: no flush until `dmem_resp`, then both flushes are 1 in that cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: gates I/D memory requests,
// holds early cache responses, and drives pipeline-register enables and flushes.
module pipeline_ctrl #(
  parameter logic [31:0] RESET_CNT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        imem_read,
  output logic [31:0] instr_out,
  input  logic        ex_dmem_read,
  input  logic        ex_dmem_write,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] load_data_out,
  input  logic        br_redirect,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            imem_done_q, imem_done_d;
  logic            dmem_done_q, dmem_done_d;
  logic [XLEN-1:0] ibuf_q, ibuf_d;
  logic [XLEN-1:0] dbuf_q, dbuf_d;
  logic [XLEN-1:0] stall_q, stall_d;
  logic [XLEN-1:0] bubble_q, bubble_d;

  logic dmem_need;
  logic imem_ok;
  logic dmem_ok;
  logic mem_stall;
  logic lu;

  // Hazard and stall qualifiers
  always_comb begin
    dmem_need = ex_dmem_read | ex_dmem_write;
    imem_ok   = imem_resp | imem_done_q;
    dmem_ok   = ~dmem_need | dmem_resp | dmem_done_q;
    mem_stall = ~(imem_ok & dmem_ok);
    lu        = idex_mem_read & (idex_rd != RW'(0)) &
                ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                 (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
  end

  // Requests, data muxes and pipeline-register control, highest priority first
  always_comb begin
    imem_read     = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_en       = 1'b0;
    idex_flush    = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    instr_out     = imem_done_q ? ibuf_q : imem_rdata;
    load_data_out = dmem_done_q ? dbuf_q : dmem_rdata;
    if (!rst) begin
      imem_read  = ~imem_done_q;
      dmem_read  = ex_dmem_read & ~dmem_done_q;
      dmem_write = ex_dmem_write & ~dmem_done_q;
      if (mem_stall) begin
        pc_en = 1'b0;
      end else if (br_redirect) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (lu) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // Capture a response that lands while the other port still stalls
  always_comb begin
    imem_done_d = imem_done_q;
    dmem_done_d = dmem_done_q;
    ibuf_d      = ibuf_q;
    dbuf_d      = dbuf_q;
    stall_d     = stall_q;
    bubble_d    = bubble_q;
    if (mem_stall) begin
      stall_d = stall_q + XLEN'(1);
      if (imem_resp && !imem_done_q) begin
        imem_done_d = 1'b1;
        ibuf_d      = imem_rdata;
      end
      if (dmem_resp && !dmem_done_q) begin
        dmem_done_d = 1'b1;
        dbuf_d      = dmem_rdata;
      end
    end else begin
      imem_done_d = 1'b0;
      dmem_done_d = 1'b0;
      if (br_redirect || lu) begin
        bubble_d = bubble_q + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      ibuf_q      <= '0;
      dbuf_q      <= '0;
      stall_q     <= RESET_CNT;
      bubble_q    <= RESET_CNT;
    end else begin
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
      ibuf_q      <= ibuf_d;
      dbuf_q      <= dbuf_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl, checked against a
// transaction-level model of fetch/data readiness and counter bookkeeping.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        imem_read;
  logic [31:0] instr_out;
  logic        ex_dmem_read;
  logic        ex_dmem_write;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] load_data_out;
  logic        br_redirect;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_use_rs1;
  logic        ifid_use_rs2;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_en;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;

  int total = 0;
  int bad   = 0;

  // Model state: which fetched/loaded words are already in hand
  bit          m_ihave, m_dhave;
  logic [31:0] m_iword, m_dword;
  logic [31:0] m_stalls, m_bubbles;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .imem_read(imem_read),
    .instr_out(instr_out),
    .ex_dmem_read(ex_dmem_read), .ex_dmem_write(ex_dmem_write),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .load_data_out(load_data_out),
    .br_redirect(br_redirect), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return idex_mem_read && (idex_rd != 5'd0) &&
           ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
  endfunction

  function automatic bit word_ready();
    return imem_resp || m_ihave;
  endfunction

  function automatic bit data_ready();
    return !(ex_dmem_read || ex_dmem_write) || dmem_resp || m_dhave;
  endfunction

  // Let combinational outputs settle, then compare everything with the model
  task automatic look(input string tag);
    logic [9:0] exp_v, obs_v;
    bit adv;
    #2;
    adv   = word_ready() && data_ready();
    exp_v = '0;
    if (!rst) begin
      exp_v[2] = !m_ihave;
      exp_v[1] = ex_dmem_read && !m_dhave;
      exp_v[0] = ex_dmem_write && !m_dhave;
      if (adv) begin
        if (br_redirect)   exp_v[9:3] = 7'b1111111;
        else if (hazard()) exp_v[9:3] = 7'b0001111;
        else               exp_v[9:3] = 7'b1101011;
      end
    end
    obs_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
             imem_read, dmem_read, dmem_write};
    chk({tag, ".ctrl"}, 32'(obs_v), 32'(exp_v));
    chk({tag, ".instr"}, instr_out, m_ihave ? m_iword : imem_rdata);
    chk({tag, ".load"}, load_data_out, m_dhave ? m_dword : dmem_rdata);
    chk({tag, ".stalls"}, stall_cycles, m_stalls);
    chk({tag, ".bubbles"}, bubble_cycles, m_bubbles);
  endtask

  // Advance one clock and apply the same edge to the model
  task automatic tick();
    bit adv;
    @(posedge clk);
    adv = word_ready() && data_ready();
    if (rst) begin
      m_ihave = 0; m_dhave = 0; m_iword = '0; m_dword = '0;
      m_stalls = '0; m_bubbles = '0;
    end else if (!adv) begin
      m_stalls = m_stalls + 32'd1;
      if (imem_resp && !m_ihave) begin m_ihave = 1; m_iword = imem_rdata; end
      if (dmem_resp && !m_dhave) begin m_dhave = 1; m_dword = dmem_rdata; end
    end else begin
      if (br_redirect || hazard()) m_bubbles = m_bubbles + 32'd1;
      m_ihave = 0;
      m_dhave = 0;
    end
    #1;
  endtask

  task automatic quiet();
    imem_resp = 1'b1; imem_rdata = $urandom; ex_dmem_read = 1'b0; ex_dmem_write = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = $urandom; br_redirect = 1'b0; idex_mem_read = 1'b0;
    idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
  endtask

  initial begin
    logic [31:0] b0;
    rst = 1'b1;
    quiet();
    m_ihave = 0; m_dhave = 0; m_iword = '0; m_dword = '0; m_stalls = '0; m_bubbles = '0;
    tick();
    look("rst1");
    tick();
    rst = 1'b0;
    look("post_rst");
    chk("post_rst.pc_en", 32'(pc_en), 32'd1);
    chk("post_rst.memwb_en", 32'(memwb_en), 32'd1);
    chk("post_rst.imem_read", 32'(imem_read), 32'd1);
    chk("post_rst.stall_cnt", stall_cycles, 32'd0);
    tick();

    // I-cache miss for three cycles
    imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look("imiss");
      chk("imiss.ifid_en", 32'(ifid_en), 32'd0);
      tick();
    end
    imem_resp = 1'b1;
    look("imiss_end");
    chk("imiss_end.pc_en", 32'(pc_en), 32'd1);
    chk("imiss_end.stall_cnt", stall_cycles, 32'd3);
    tick();

    // Overlap: I responds first, D responds three cycles later
    ex_dmem_read = 1'b1; imem_resp = 1'b0;
    look("ovl0"); tick();
    imem_resp = 1'b1; imem_rdata = 32'h00A00093;
    look("ovl1"); tick();
    imem_resp = 1'b0;
    for (int i = 2; i < 4; i++) begin
      imem_rdata = $urandom;
      look("ovl_wait");
      chk("ovl_wait.imem_read", 32'(imem_read), 32'd0);
      tick();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; imem_rdata = 32'h12345678;
    look("ovl4");
    chk("ovl4.imem_read", 32'(imem_read), 32'd0);
    chk("ovl4.instr", instr_out, 32'h00A00093);
    chk("ovl4.load", load_data_out, 32'hDEADBEEF);
    chk("ovl4.exmem_en", 32'(exmem_en), 32'd1);
    tick();
    quiet();
    look("ovl5");
    chk("ovl5.imem_read", 32'(imem_read), 32'd1);
    tick();

    // Load-use hazard, then the same with rd=x0
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1'b1;
    b0 = m_bubbles;
    look("lu");
    chk("lu.pc_en", 32'(pc_en), 32'd0);
    chk("lu.ifid_en", 32'(ifid_en), 32'd0);
    chk("lu.idex_flush", 32'(idex_flush), 32'd1);
    tick();
    idex_rd = 5'd0; ifid_rs2 = 5'd0;
    look("lu_x0");
    chk("lu.bubble_inc", bubble_cycles, b0 + 32'd1);
    chk("lu_x0.pc_en", 32'(pc_en), 32'd1);
    tick();
    look("lu_x0_after");
    chk("lu_x0.bubble_same", bubble_cycles, b0 + 32'd1);

    // Redirect together with load-use
    idex_rd = 5'd5; ifid_rs2 = 5'd5; br_redirect = 1'b1;
    b0 = m_bubbles;
    look("br_lu");
    chk("br_lu.ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br_lu.idex_flush", 32'(idex_flush), 32'd1);
    chk("br_lu.pc_en", 32'(pc_en), 32'd1);
    tick();
    quiet();
    look("br_lu_after");
    chk("br_lu.bubble_inc", bubble_cycles, b0 + 32'd1);
    tick();

    // Redirect held during a D-miss
    br_redirect = 1'b1; ex_dmem_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      look("br_dmiss");
      chk("br_dmiss.ifid_flush", 32'(ifid_flush), 32'd0);
      tick();
    end
    dmem_resp = 1'b1;
    look("br_dmiss_end");
    chk("br_dmiss_end.ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br_dmiss_end.idex_flush", 32'(idex_flush), 32'd1);
    tick();
    quiet();

    // Reset in the middle of a stall discards the captured fetch
    ex_dmem_read = 1'b1; imem_rdata = 32'hCAFEF00D;
    look("mid_stall"); tick();
    rst = 1'b1;
    look("mid_rst");
    chk("mid_rst.imem_read", 32'(imem_read), 32'd0);
    tick();
    rst = 1'b0; imem_resp = 1'b0; ex_dmem_read = 1'b0;
    look("after_mid_rst");
    chk("after_mid_rst.imem_read", 32'(imem_read), 32'd1);
    tick();
    quiet();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      imem_resp     = ($urandom_range(0, 9) < 6);
      imem_rdata    = $urandom;
      ex_dmem_read  = ($urandom_range(0, 2) == 0);
      ex_dmem_write = !ex_dmem_read && ($urandom_range(0, 3) == 0);
      dmem_resp     = ($urandom_range(0, 1) == 1);
      dmem_rdata    = $urandom;
      br_redirect   = ($urandom_range(0, 5) == 0);
      idex_mem_read = ($urandom_range(0, 1) == 1);
      idex_rd       = 5'($urandom_range(0, 3));
      ifid_rs1      = 5'($urandom_range(0, 3));
      ifid_rs2      = 5'($urandom_range(0, 3));
      ifid_use_rs1  = ($urandom_range(0, 1) == 1);
      ifid_use_rs2  = ($urandom_range(0, 1) == 1);
      look("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
